// File: rtl/lbist_pkg.sv
// Shared state encoding, constants and sizing helper for the LBIST sequencer.
package lbist_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_INIT  = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_CHECK = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // rpg raises END right after a reseed; ignore it until this many patterns have gone out.
  localparam int unsigned RPG_END_MASK = 2;

  // Bits needed to hold the values 0..n inclusive, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lbist_ctrl_if.sv
// Handshake and status bundle between an LBIST requester (master) and lbist_ctrl (slave).
interface lbist_ctrl_if #(
  parameter int unsigned SIG_BITS = 16,
  parameter int unsigned CNT_W    = 4
);

  logic                start;
  logic                abort;
  logic                rpg_end;
  logic [SIG_BITS-1:0] signature;

  logic                rpg_rst;
  logic                misr_clr;
  logic                misr_en;
  logic                busy;
  logic                done;
  logic                pass;
  logic                fail;
  logic                wrap_err;
  logic [CNT_W-1:0]    pat_cnt;

  modport master (
    output start, abort, rpg_end, signature,
    input  rpg_rst, misr_clr, misr_en, busy, done, pass, fail, wrap_err, pat_cnt
  );

  modport slave (
    input  start, abort, rpg_end, signature,
    output rpg_rst, misr_clr, misr_en, busy, done, pass, fail, wrap_err, pat_cnt
  );

endinterface

// File: rtl/lbist_cycle_counter.sv
// Up-counter with synchronous clear and a terminal-count flag; used for patterns and settling.
module lbist_cycle_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TC    = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == WIDTH'(TC));

endmodule

// File: rtl/lbist_ctrl.sv
// LBIST sequencer: reseeds rpg, clears the MISR, applies a pattern budget, drains the CUT
// and grades the final signature against a golden value.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned         BITS         = 4,
  parameter int unsigned         NUM_PATTERNS = (1 << BITS) - 1,
  parameter int unsigned         SETTLE       = 2,
  parameter int unsigned         SIG_BITS     = 16,
  parameter logic [SIG_BITS-1:0] GOLDEN_SIG   = {SIG_BITS{1'b0}}
) (
  input logic         i_clk,
  input logic         i_rst,
  lbist_ctrl_if.slave io_bus
);

  localparam int unsigned CNT_W  = cnt_w(NUM_PATTERNS);
  localparam int unsigned SET_W  = cnt_w(SETTLE);
  localparam int unsigned SET_TC = (SETTLE > 0) ? SETTLE - 1 : 0;

  state_t           r_state;
  state_t           w_state_d;
  logic             w_abort;
  logic             w_pat_clr;
  logic             w_pat_en;
  logic             w_pat_tc;
  logic             w_set_clr;
  logic             w_set_en;
  logic             w_set_tc;
  logic             w_sig_match;
  logic             w_wrap_hit;
  logic [CNT_W-1:0] w_pat_cnt;
  logic [SET_W-1:0] w_set_cnt;
  logic             w_unused_set_cnt;
  logic             r_pass;
  logic             r_fail;
  logic             r_wrap;

  // Abort only means something once a test has left IDLE.
  assign w_abort     = io_bus.abort && (r_state != ST_IDLE);
  assign w_pat_clr   = w_abort || (r_state == ST_INIT);
  assign w_pat_en    = (r_state == ST_RUN);
  assign w_set_clr   = (r_state != ST_FLUSH);
  assign w_set_en    = (r_state == ST_FLUSH);
  assign w_sig_match = (io_bus.signature == GOLDEN_SIG);
  assign w_wrap_hit  = (r_state == ST_RUN) && io_bus.rpg_end &&
                       (32'(w_pat_cnt) >= RPG_END_MASK);

  lbist_cycle_counter #(
    .WIDTH (CNT_W),
    .TC    (NUM_PATTERNS - 1)
  ) u_pat_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_pat_clr),
    .i_en    (w_pat_en),
    .o_count (w_pat_cnt),
    .o_tc    (w_pat_tc)
  );

  lbist_cycle_counter #(
    .WIDTH (SET_W),
    .TC    (SET_TC)
  ) u_set_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_set_clr),
    .i_en    (w_set_en),
    .o_count (w_set_cnt),
    .o_tc    (w_set_tc)
  );

  // Only the terminal flag of the settle counter drives the FSM.
  assign w_unused_set_cnt = ^w_set_cnt;

  always_comb begin
    w_state_d = r_state;
    if (w_abort) begin
      w_state_d = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (io_bus.start) w_state_d = ST_INIT;
        ST_INIT:          w_state_d = ST_RUN;
        ST_RUN: begin
          if (w_pat_tc) w_state_d = (SETTLE == 0) ? ST_CHECK : ST_FLUSH;
        end
        ST_FLUSH:         if (w_set_tc) w_state_d = ST_CHECK;
        ST_CHECK:         w_state_d = ST_DONE;
        default:          w_state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort || (r_state == ST_INIT)) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (r_state == ST_CHECK) begin
        r_pass <= w_sig_match;
        r_fail <= !w_sig_match;
      end
      if (w_wrap_hit) begin
        r_wrap <= 1'b1;
      end
    end
  end

  assign io_bus.rpg_rst  = (r_state == ST_INIT);
  assign io_bus.misr_clr = (r_state == ST_INIT);
  assign io_bus.misr_en  = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign io_bus.busy     = (r_state == ST_INIT) || (r_state == ST_RUN) ||
                           (r_state == ST_FLUSH) || (r_state == ST_CHECK);
  assign io_bus.done     = (r_state == ST_DONE);
  assign io_bus.pass     = r_pass;
  assign io_bus.fail     = r_fail;
  assign io_bus.wrap_err = r_wrap;
  assign io_bus.pat_cnt  = w_pat_cnt;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Directed bench for lbist_ctrl: three parameterisations, scoreboard of expected run results.
module tb_lbist_ctrl;
  import lbist_pkg::*;

  localparam logic [15:0]  GOLD = 16'hA5C3;
  localparam int unsigned  CW_A = cnt_w(15);
  localparam int unsigned  CW_W = cnt_w(20);

  typedef struct {
    logic        pass_e;
    logic        fail_e;
    logic        wrap_e;
    int unsigned cnt_e;
    int unsigned lat_e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
  exp_t        sb_q[$];

  lbist_ctrl_if #(.SIG_BITS(16), .CNT_W(CW_A)) bus_a ();
  lbist_ctrl_if #(.SIG_BITS(16), .CNT_W(CW_W)) bus_w ();
  lbist_ctrl_if #(.SIG_BITS(16), .CNT_W(CW_A)) bus_z ();

  lbist_ctrl #(.BITS(4), .SETTLE(2), .SIG_BITS(16), .GOLDEN_SIG(GOLD)) u_dut_a (
    .i_clk (clk), .i_rst (rst), .io_bus (bus_a)
  );
  lbist_ctrl #(.BITS(4), .NUM_PATTERNS(20), .SETTLE(2), .SIG_BITS(16), .GOLDEN_SIG(GOLD)) u_dut_w (
    .i_clk (clk), .i_rst (rst), .io_bus (bus_w)
  );
  lbist_ctrl #(.BITS(4), .SETTLE(0), .SIG_BITS(16), .GOLDEN_SIG(GOLD)) u_dut_z (
    .i_clk (clk), .i_rst (rst), .io_bus (bus_z)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time budget exceeded, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string who, input int unsigned k, input logic p, input logic f,
                          input logic w, input int unsigned c);
    exp_t e;
    e = sb_q.pop_front();
    chk({who, "_latency"}, k, e.lat_e);
    chk({who, "_pass"}, p, e.pass_e);
    chk({who, "_fail"}, f, e.fail_e);
    chk({who, "_wrap"}, w, e.wrap_e);
    chk({who, "_pat_cnt"}, c, e.cnt_e);
  endtask

  // Full 15-pattern run on dut_a with per-cycle output checks; poke re-asserts start mid-RUN.
  task automatic run_a(input logic [15:0] sig, input bit poke);
    bit seen;
    sb_q.push_back('{pass_e: (sig == GOLD), fail_e: (sig != GOLD), wrap_e: 1'b0,
                     cnt_e: 15, lat_e: 20});
    bus_a.signature = sig;
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      bus_a.start = poke && (k == 6);
      chk("a_rpg_rst", bus_a.rpg_rst, k == 1);
      chk("a_misr_clr", bus_a.misr_clr, k == 1);
      chk("a_misr_en", bus_a.misr_en, k >= 2 && k <= 18);
      chk("a_busy", bus_a.busy, k >= 1 && k <= 19);
      chk("a_done", bus_a.done, k == 20);
      if (k >= 2) begin
        chk("a_pat_cnt_run", bus_a.pat_cnt, (k - 2 > 15) ? 15 : k - 2);
        chk("a_wrap_run", bus_a.wrap_err, 1'b0);
      end
      if (bus_a.done) begin
        seen = 1'b1;
        sb_check("a", k, bus_a.pass, bus_a.fail, bus_a.wrap_err, bus_a.pat_cnt);
      end
    end
    if (!seen) chk("a_done_timeout", bus_a.done, 1'b1);
  endtask

  initial begin
    bit seen;
    bit found;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.rpg_end = 1'b0; bus_a.signature = GOLD;
    bus_w.start = 1'b0; bus_w.abort = 1'b0; bus_w.rpg_end = 1'b0; bus_w.signature = GOLD;
    bus_z.start = 1'b0; bus_z.abort = 1'b0; bus_z.rpg_end = 1'b0; bus_z.signature = GOLD;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_rpg_rst", bus_a.rpg_rst, 1'b0);
    chk("rst_misr_clr", bus_a.misr_clr, 1'b0);
    chk("rst_misr_en", bus_a.misr_en, 1'b0);
    chk("rst_busy", bus_a.busy, 1'b0);
    chk("rst_done", bus_a.done, 1'b0);
    chk("rst_pass", bus_a.pass, 1'b0);
    chk("rst_fail", bus_a.fail, 1'b0);
    chk("rst_wrap", bus_a.wrap_err, 1'b0);
    chk("rst_pat_cnt", bus_a.pat_cnt, 0);
    chk("rst_w_busy", bus_w.busy, 1'b0);
    rst = 1'b0;

    // Nominal pass, then signature mismatch
    run_a(GOLD, 1'b0);
    run_a(GOLD ^ 16'h0001, 1'b0);

    // Abort at pat_cnt 7 with start also high
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus_a.misr_en && bus_a.pat_cnt == 7) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) chk("abort_reach", bus_a.pat_cnt, 7);
    bus_a.abort = 1'b1; bus_a.start = 1'b1;
    @(negedge clk); bus_a.abort = 1'b0; bus_a.start = 1'b0;
    chk("abort_busy", bus_a.busy, 1'b0);
    chk("abort_pat_cnt", bus_a.pat_cnt, 0);
    chk("abort_misr_en", bus_a.misr_en, 1'b0);
    chk("abort_rpg_rst", bus_a.rpg_rst, 1'b0);
    chk("abort_fail", bus_a.fail, 1'b0);
    @(negedge clk);
    chk("abort_no_init", bus_a.rpg_rst, 1'b0);
    chk("abort_idle_busy", bus_a.busy, 1'b0);

    // Synchronous reset in FLUSH, then a clean rerun
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (bus_a.misr_en && bus_a.pat_cnt == 15) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) chk("flush_reach", bus_a.pat_cnt, 15);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mrst_misr_en", bus_a.misr_en, 1'b0);
    chk("mrst_busy", bus_a.busy, 1'b0);
    chk("mrst_done", bus_a.done, 1'b0);
    chk("mrst_pat_cnt", bus_a.pat_cnt, 0);
    chk("mrst_pass", bus_a.pass, 1'b0);
    run_a(GOLD, 1'b0);

    // Start during RUN is ignored
    run_a(GOLD, 1'b1);

    // Wrap detection with a 20-pattern budget
    sb_q.push_back('{pass_e: 1'b1, fail_e: 1'b0, wrap_e: 1'b1, cnt_e: 20, lat_e: 25});
    @(negedge clk); bus_w.start = 1'b1;
    @(negedge clk); bus_w.start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      bus_w.rpg_end = (k == 3) || (k == 17);
      if (k == 3)  chk("w_cnt_at_mask", bus_w.pat_cnt, 1);
      if (k == 4)  chk("w_end_masked", bus_w.wrap_err, 1'b0);
      if (k == 17) chk("w_cnt_at_wrap", bus_w.pat_cnt, 15);
      if (k == 17) chk("w_wrap_before", bus_w.wrap_err, 1'b0);
      if (k == 18) chk("w_wrap_set", bus_w.wrap_err, 1'b1);
      if (bus_w.done) begin
        seen = 1'b1;
        sb_check("w", k, bus_w.pass, bus_w.fail, bus_w.wrap_err, bus_w.pat_cnt);
      end
    end
    bus_w.rpg_end = 1'b0;
    if (!seen) chk("w_done_timeout", bus_w.done, 1'b1);

    // SETTLE=0: RUN goes straight to CHECK
    sb_q.push_back('{pass_e: 1'b1, fail_e: 1'b0, wrap_e: 1'b0, cnt_e: 15, lat_e: 18});
    @(negedge clk); bus_z.start = 1'b1;
    @(negedge clk); bus_z.start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 16) chk("z_misr_en_last", bus_z.misr_en, 1'b1);
      if (k == 17) chk("z_misr_en_check", bus_z.misr_en, 1'b0);
      if (k == 17) chk("z_busy_check", bus_z.busy, 1'b1);
      if (bus_z.done) begin
        seen = 1'b1;
        sb_check("z", k, bus_z.pass, bus_z.fail, bus_z.wrap_err, bus_z.pat_cnt);
      end
    end
    if (!seen) chk("z_done_timeout", bus_z.done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
